// File: rtl/operand_expand_pkg.sv
// Shared widths, fixed-point constants and FSM encoding for the CORDIC operand
// formatter and the output rounding stage.
package operand_expand_pkg;

  localparam int IN_W   = 8;
  localparam int OUT_W  = 18;
  localparam int FRAC_W = 16;

  localparam logic [OUT_W-1:0] FIX_ONE       = 18'h10000;
  localparam logic [OUT_W-1:0] FIX_MINUS_ONE = 18'h30000;
  localparam logic [IN_W-1:0]  Q17_MAX       = 8'h7F;

  typedef enum logic {
    WAIT_X,
    WAIT_Y
  } state_t;

endpackage

// File: rtl/q17_expand.sv
// Widens a Q1.7 byte to the core's Q2.16 format; optionally maps the clamped
// maximum code back to exactly +1.0.
module q17_expand
  import operand_expand_pkg::*;
#(
  parameter bit RESTORE_ONE = 1'b1
) (
  input  logic [IN_W-1:0]  in_byte,
  output logic [OUT_W-1:0] expanded
);

  localparam logic [IN_W-1:0] Q17_MIN = {1'b1, {(IN_W-1){1'b0}}};

  always_comb begin
    expanded = {in_byte[IN_W-1], in_byte[IN_W-1], in_byte[IN_W-2:0],
                {(FRAC_W-IN_W+1){1'b0}}};
    if (RESTORE_ONE && (in_byte == Q17_MAX)) begin
      expanded = FIX_ONE;
    end else if (in_byte == Q17_MIN) begin
      expanded = FIX_MINUS_ONE;
    end
  end

endmodule

// File: rtl/operand_expand.sv
// Collects X/Y operand bytes, widens them and hands well-formed pairs to the
// CORDIC core through a registered valid/ready output.
module operand_expand
  import operand_expand_pkg::*;
#(
  parameter bit RESTORE_ONE = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [IN_W-1:0]   in_data,
  input  logic              in_first,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [OUT_W-1:0]  out_x,
  output logic [OUT_W-1:0]  out_y,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              sync_err
);

  state_t           state, state_next;
  logic [OUT_W-1:0] x_hold, x_hold_next;
  logic [OUT_W-1:0] expanded;
  logic             accept;
  logic             load;
  logic             err_next;

  q17_expand #(
    .RESTORE_ONE(RESTORE_ONE)
  ) u_expand (
    .in_byte (in_data),
    .expanded(expanded)
  );

  // X capture never touches the output register, so only Y waits on it.
  assign in_ready = rst_n && ((state == WAIT_X) || !out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_next  = state;
    x_hold_next = x_hold;
    load        = 1'b0;
    err_next    = 1'b0;
    if (accept) begin
      case (state)
        WAIT_X: begin
          if (in_first) begin
            x_hold_next = expanded;
            state_next  = WAIT_Y;
          end else begin
            err_next = 1'b1;
          end
        end
        WAIT_Y: begin
          if (in_first) begin
            err_next    = 1'b1;
            x_hold_next = expanded;
          end else begin
            load       = 1'b1;
            state_next = WAIT_X;
          end
        end
        default: state_next = WAIT_X;
      endcase
    end
  end

  // Capture / output register stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= WAIT_X;
      x_hold    <= '0;
      out_x     <= '0;
      out_y     <= '0;
      out_valid <= 1'b0;
      sync_err  <= 1'b0;
    end else begin
      state    <= state_next;
      x_hold   <= x_hold_next;
      sync_err <= err_next;
      if (load) begin
        out_x     <= x_hold;
        out_y     <= expanded;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_operand_expand.sv
// Directed and randomized checks of operand_expand against a value-level
// model of the Q1.7 to Q2.16 widening and pair framing.
module tb_operand_expand;

  logic        clk;
  logic        rst_n;
  logic [7:0]  in_data;
  logic        in_first;
  logic        in_valid;
  logic        in_ready;
  logic [17:0] out_x;
  logic [17:0] out_y;
  logic        out_valid;
  logic        out_ready;
  logic        sync_err;

  logic        in_ready0;
  logic [17:0] out_x0;
  logic [17:0] out_y0;
  logic        out_valid0;
  logic        sync_err0;

  int checks = 0;
  int errors = 0;

  operand_expand #(.RESTORE_ONE(1'b1)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (in_data),
    .in_first (in_first),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_x    (out_x),
    .out_y    (out_y),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sync_err (sync_err)
  );

  operand_expand #(.RESTORE_ONE(1'b0)) dut0 (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (in_data),
    .in_first (in_first),
    .in_valid (in_valid),
    .in_ready (in_ready0),
    .out_x    (out_x0),
    .out_y    (out_y0),
    .out_valid(out_valid0),
    .out_ready(out_ready),
    .sync_err (sync_err0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Numeric value of a Q1.7 byte scaled to 16 fraction bits.
  function automatic logic [17:0] ref_expand(input logic [7:0] b, input bit restore);
    int v;
    if (restore && b == 8'h7F) v = 65536;
    else v = $signed(b) * 512;
    return v[17:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic first);
    int n = 0;
    in_valid = 1'b1;
    in_data  = b;
    in_first = first;
    #1;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    chk("send_ready", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
  endtask

  logic [7:0] xb, yb;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; in_first = 1'b0; out_ready = 1'b1;
    #2;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_x", {14'd0, out_x}, 32'd0);
    chk("rst_out_y", {14'd0, out_y}, 32'd0);
    chk("rst_sync_err", {31'd0, sync_err}, 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // basic pair
    send_byte(8'h40, 1'b1);
    send_byte(8'hC0, 1'b0);
    chk("basic_valid", {31'd0, out_valid}, 32'd1);
    chk("basic_x", {14'd0, out_x}, 32'h08000);
    chk("basic_y", {14'd0, out_y}, 32'h38000);
    tick();
    chk("basic_valid_drop", {31'd0, out_valid}, 32'd0);
    chk("basic_no_err", {31'd0, sync_err}, 32'd0);

    // edge codes on both parameterisations
    send_byte(8'h7F, 1'b1);
    send_byte(8'h80, 1'b0);
    chk("edge_x_restore", {14'd0, out_x}, {14'd0, ref_expand(8'h7F, 1'b1)});
    chk("edge_y_restore", {14'd0, out_y}, 32'h30000);
    chk("edge_x_norestore", {14'd0, out_x0}, 32'h0FE00);
    chk("edge_y_norestore", {14'd0, out_y0}, 32'h30000);
    tick();

    // backpressure
    out_ready = 1'b0;
    send_byte(8'h20, 1'b1);
    send_byte(8'hE0, 1'b0);
    chk("bp_x", {14'd0, out_x}, 32'h04000);
    chk("bp_y", {14'd0, out_y}, 32'h3C000);
    tick(); tick();
    chk("bp_hold_valid", {31'd0, out_valid}, 32'd1);
    chk("bp_hold_x", {14'd0, out_x}, 32'h04000);
    send_byte(8'h11, 1'b1);
    chk("bp_x_taken_hold_y", {14'd0, out_y}, 32'h3C000);
    in_valid = 1'b1; in_data = 8'hF0; in_first = 1'b0;
    #1;
    chk("bp_y_blocked", {31'd0, in_ready}, 32'd0);
    tick();
    chk("bp_y_blocked2", {31'd0, in_ready}, 32'd0);
    chk("bp_hold_x2", {14'd0, out_x}, 32'h04000);
    out_ready = 1'b1;
    #1;
    chk("bp_y_released", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    chk("bp_nobubble_valid", {31'd0, out_valid}, 32'd1);
    chk("bp_new_x", {14'd0, out_x}, {14'd0, ref_expand(8'h11, 1'b1)});
    chk("bp_new_y", {14'd0, out_y}, {14'd0, ref_expand(8'hF0, 1'b1)});
    tick();
    chk("bp_drained", {31'd0, out_valid}, 32'd0);

    // framing: repeated X
    send_byte(8'h10, 1'b1);
    chk("frm_first_ok", {31'd0, sync_err}, 32'd0);
    send_byte(8'h30, 1'b1);
    chk("frm_dup_x_err", {31'd0, sync_err}, 32'd1);
    send_byte(8'h50, 1'b0);
    chk("frm_err_one_cycle", {31'd0, sync_err}, 32'd0);
    chk("frm_pair_x", {14'd0, out_x}, 32'h06000);
    chk("frm_pair_y", {14'd0, out_y}, 32'h0A000);
    // framing: lone Y in WAIT_X
    send_byte(8'h22, 1'b0);
    chk("frm_lone_err", {31'd0, sync_err}, 32'd1);
    chk("frm_lone_dropped", {31'd0, out_valid}, 32'd0);
    tick();
    chk("frm_lone_err_clear", {31'd0, sync_err}, 32'd0);
    send_byte(8'h33, 1'b1);
    send_byte(8'h44, 1'b0);
    chk("frm_recover_x", {14'd0, out_x}, {14'd0, ref_expand(8'h33, 1'b1)});
    chk("frm_recover_y", {14'd0, out_y}, {14'd0, ref_expand(8'h44, 1'b1)});
    tick();

    // reset mid-pair with a pending output pair
    out_ready = 1'b0;
    send_byte(8'h01, 1'b1);
    send_byte(8'h02, 1'b0);
    send_byte(8'h40, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_x", {14'd0, out_x}, 32'd0);
    chk("mid_rst_y", {14'd0, out_y}, 32'd0);
    tick(); tick();
    chk("mid_rst_in_ready2", {31'd0, in_ready}, 32'd0);
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick();
    send_byte(8'h12, 1'b0);
    chk("mid_rst_sync_err", {31'd0, sync_err}, 32'd1);
    chk("mid_rst_no_pair", {31'd0, out_valid}, 32'd0);
    tick();

    // streaming random pairs back-to-back
    for (int i = 0; i < 16; i++) begin
      xb = 8'($urandom_range(0, 255));
      yb = 8'($urandom_range(0, 255));
      in_valid = 1'b1; in_first = 1'b1; in_data = xb;
      #1;
      chk("str_x_ready", {31'd0, in_ready}, 32'd1);
      tick();
      chk("str_gap", {31'd0, out_valid}, 32'd0);
      in_first = 1'b0; in_data = yb;
      #1;
      chk("str_y_ready", {31'd0, in_ready}, 32'd1);
      tick();
      chk("str_valid", {31'd0, out_valid}, 32'd1);
      chk("str_x", {14'd0, out_x}, {14'd0, ref_expand(xb, 1'b1)});
      chk("str_y", {14'd0, out_y}, {14'd0, ref_expand(yb, 1'b1)});
      chk("str_x_norestore", {14'd0, out_x0}, {14'd0, ref_expand(xb, 1'b0)});
      chk("str_no_err", {31'd0, sync_err}, 32'd0);
    end
    in_valid = 1'b0;
    tick();
    chk("str_end_drain", {31'd0, out_valid}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/operand_expand.md
# operand_expand

Input-side formatter for the 8-bit CORDIC datapath and the inverse of the output rounding stage. It accepts a byte stream of Q1.7 operands (X byte, then Y byte), widens each to the core's 18-bit internal format (bit 17 sign, bit 16 integer, bits 15:0 fraction), and presents the X/Y pair to the core through a registered valid/ready output. Framing errors and backpressure are handled here, so the core receives only well-formed pairs.

## Interface
- RESTORE_ONE, default 1: when 1, byte 8'h7F expands to +1.0 (18'h10000), undoing the output stage's clamp of 1.0 to 0.992188. When 0, 8'h7F expands exactly to 18'h0FE00.
- clk  in  1  sole clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_data  in  8  Q1.7 two's-complement operand byte.
- in_first  in  1  marks `in_data` as the X byte of a pair.
- in_valid  in  1  byte offered.
- in_ready  out  1  byte accepted when `in_valid && in_ready`.
- out_x  out  18  expanded X, Q2.16 format.
- out_y  out  18  expanded Y, Q2.16 format.
- out_valid  out  1  pair available.
- out_ready  in  1  pair consumed when `out_valid && out_ready`.
- sync_err  out  1  one-cycle pulse on a framing violation.

## Operation
- Expansion, per byte b: {b[7], b[7], b[6:0], 9'b0}. This is value-exact, with no rounding.
  - With RESTORE_ONE=1, b=8'h7F is the only exception and yields 18'h10000.
  - b=8'h80 yields 18'h30000 (-1.0).
- FSM has two states, WAIT_X (reset state) and WAIT_Y.
  - WAIT_X, accepted byte with in_first=1: store expanded value in x_hold; go to WAIT_Y.
  - WAIT_X, accepted byte with in_first=0: drop the byte; pulse sync_err; stay in WAIT_X.
  - WAIT_Y, accepted byte with in_first=0: load {x_hold, expanded byte} into out_x/out_y; set out_valid; go to WAIT_X.
  - WAIT_Y, accepted byte with in_first=1: pulse sync_err; overwrite x_hold with the new byte; stay in WAIT_Y. The stale X is discarded.
- in_ready:
  - In WAIT_X, in_ready = 1, because x_hold is independent of the output register.
  - In WAIT_Y, in_ready = !out_valid || out_ready.
  - in_ready is combinational from state and out_valid/out_ready, and is 0 while rst_n is low.
- Output register:
  - out_x/out_y stay stable while out_valid && !out_ready.
  - out_valid clears on handshake unless a new pair loads on the same edge, in which case it stays 1 with the new data.
- Simultaneous drain and load in WAIT_Y is legal and produces no bubble.

## Timing
- Reset values: out_x=0, out_y=0, out_valid=0, sync_err=0, state=WAIT_X, x_hold=0.
- Reset mid-pair discards x_hold and any pending output pair.
- Latency: out_valid rises on the edge that accepts the Y byte, so data is visible the cycle after the Y handshake.
- Throughput: one pair per 2 clk with out_ready held high.
- sync_err is registered and asserts the cycle after the offending handshake, for exactly 1 cycle.
- No combinational path from in_data to the outputs.

## Structure
- The shared package holds:
  - IN_W=8, OUT_W=18, FRAC_W=16.
  - Constants FIX_ONE=18'h10000, FIX_MINUS_ONE=18'h30000, Q17_MAX=8'h7F.
  - FSM state enum {WAIT_X, WAIT_Y}.
- The output rounding stage imports the same constants.
- One combinational sub-module, `q17_expand` (byte in, 18-bit out, RESTORE_ONE parameter), is instantiated once and shared by X and Y capture.

## Test plan
- Basic pair: X=8'h40 (first), then Y=8'hC0, out_ready=1 -> out_x=18'h08000, out_y=18'h38000, out_valid high for 1 cycle.
- Edge codes:
  - RESTORE_ONE=1: X=8'h7F, Y=8'h80 -> out_x=18'h10000, out_y=18'h30000.
  - RESTORE_ONE=0: X=8'h7F -> out_x=18'h0FE00.
- Backpressure:
  - out_ready=0 after pair (8'h20, 8'hE0) -> outputs hold 18'h04000/18'h3C000.
  - Next X is accepted; the following Y sees in_ready=0 until out_ready=1.
  - Then the new pair loads on the drain edge with no bubble.
- Framing:
  - in_first=1 on 8'h10 then 8'h30, then in_first=0 on 8'h50 -> one sync_err pulse; pair = 18'h06000/18'h0A000.
  - A lone in_first=0 byte in WAIT_X -> dropped, one sync_err pulse.
- Reset mid-pair: X=8'h40 accepted, rst_n low for 2 cycles -> all outputs 0, in_ready=0 during reset, and the next in_first=0 byte raises sync_err.
- Streaming: 16 random pairs back-to-back, out_ready=1 -> each output matches the reference expansion; one pair every 2 clk.
